// File: rtl/fetch_pair_buffer.sv
// rtl/fetch_pair_buffer.sv - compacting 2-in/2-out instruction buffer between IF and dual-decode ID
// Optional feature: define FB_BYPASS_EN to forward a push straight to ID while the buffer is empty.
`ifndef INST_NOP
`define INST_NOP 32'h03400000
`endif

module fetch_pair_buffer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_readygo,
  output logic        fb_allowin,
  input  logic [1:0]  if_fb_valid,
  input  logic [31:0] if_fb_pc0,
  input  logic [31:0] if_fb_pc1,
  input  logic [31:0] if_fb_inst0,
  input  logic [31:0] if_fb_inst1,
  input  logic [6:0]  if_fb_excp0,
  input  logic [6:0]  if_fb_excp1,
  output logic        fb_readygo,
  input  logic        id_allowin,
  output logic [1:0]  fb_id_valid,
  output logic [31:0] fb_id_pc0,
  output logic [31:0] fb_id_pc1,
  output logic [31:0] fb_id_inst0,
  output logic [31:0] fb_id_inst1,
  output logic [6:0]  fb_id_excp0,
  output logic [6:0]  fb_id_excp1
);

  // Room for a full two-instruction packet means at most DEPTH-2 entries occupied.
  localparam logic [PTR_W:0] ALLOW_MAX = (PTR_W+1)'(DEPTH - 2);
  localparam logic [PTR_W:0] TWO       = (PTR_W+1)'(2);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [31:0] pc_q   [DEPTH];
  logic [31:0] pc_d   [DEPTH];
  logic [31:0] inst_q [DEPTH];
  logic [31:0] inst_d [DEPTH];
  logic [6:0]  excp_q [DEPTH];
  logic [6:0]  excp_d [DEPTH];

  logic [1:0]  npush;
  logic [1:0]  c_valid;
  logic [31:0] c_pc0, c_pc1, c_inst0, c_inst1;
  logic [6:0]  c_excp0, c_excp1;

  logic             push_en;
  logic             st_valid0;
  logic             st_valid1;
  logic             st_pop;
  logic [1:0]       npop;
  logic             byp_take;
  logic             wr_en;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;

  // Compact the fetch packet so a lone slot1 instruction moves down into slot0.
  always_comb begin
    npush   = {1'b0, if_fb_valid[0]} + {1'b0, if_fb_valid[1]};
    c_valid = (npush == 2'd2) ? 2'b11 : ((npush == 2'd1) ? 2'b01 : 2'b00);
    c_pc0   = if_fb_valid[0] ? if_fb_pc0   : if_fb_pc1;
    c_inst0 = if_fb_valid[0] ? if_fb_inst0 : if_fb_inst1;
    c_excp0 = if_fb_valid[0] ? if_fb_excp0 : if_fb_excp1;
    c_pc1   = if_fb_pc1;
    c_inst1 = if_fb_inst1;
    c_excp1 = if_fb_excp1;
  end

  assign fb_allowin = (count_q <= ALLOW_MAX);
  assign push_en    = if_readygo && fb_allowin;
  assign st_valid0  = (count_q != '0);
  assign st_valid1  = (count_q >= TWO);
  assign head_p1    = head_q + PTR_W'(1);
  assign tail_p1    = tail_q + PTR_W'(1);
  assign st_pop     = st_valid0 && id_allowin;
  assign npop       = !st_pop ? 2'd0 : (st_valid1 ? 2'd2 : 2'd1);

`ifdef FB_BYPASS_EN
  logic byp_active;
  assign byp_active = push_en && !st_valid0 && (npush != 2'd0);
  assign byp_take   = byp_active && id_allowin;
`else
  assign byp_take   = 1'b0;
`endif

  // A bypassed packet that ID consumes in the same cycle is never stored.
  assign wr_en = push_en && !byp_take;

  // Present the two oldest entries; empty slots show a NOP with zero PC and exception.
  always_comb begin
    fb_id_valid = {st_valid1, st_valid0};
    fb_id_pc0   = st_valid0 ? pc_q[head_q]    : 32'h0;
    fb_id_inst0 = st_valid0 ? inst_q[head_q]  : `INST_NOP;
    fb_id_excp0 = st_valid0 ? excp_q[head_q]  : 7'h0;
    fb_id_pc1   = st_valid1 ? pc_q[head_p1]   : 32'h0;
    fb_id_inst1 = st_valid1 ? inst_q[head_p1] : `INST_NOP;
    fb_id_excp1 = st_valid1 ? excp_q[head_p1] : 7'h0;
`ifdef FB_BYPASS_EN
    if (byp_active) begin
      fb_id_valid = c_valid;
      fb_id_pc0   = c_pc0;
      fb_id_inst0 = c_inst0;
      fb_id_excp0 = c_excp0;
      fb_id_pc1   = c_valid[1] ? c_pc1   : 32'h0;
      fb_id_inst1 = c_valid[1] ? c_inst1 : `INST_NOP;
      fb_id_excp1 = c_valid[1] ? c_excp1 : 7'h0;
    end
`endif
    fb_readygo = fb_id_valid[0];
  end

  // Pointer and occupancy update; flush wins over any push or pop in the same cycle.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(npop);
      if (wr_en) begin
        tail_d = tail_q + PTR_W'(npush);
      end
      count_d = count_q + (wr_en ? (PTR_W+1)'(npush) : '0) - (PTR_W+1)'(npop);
    end
  end

  // Payload write: compacted slot0 at tail, slot1 (only for full packets) at tail+1.
  always_comb begin
    pc_d   = pc_q;
    inst_d = inst_q;
    excp_d = excp_q;
    if (wr_en && !flush) begin
      if (npush != 2'd0) begin
        pc_d[tail_q]   = c_pc0;
        inst_d[tail_q] = c_inst0;
        excp_d[tail_q] = c_excp0;
      end
      if (npush == 2'd2) begin
        pc_d[tail_p1]   = c_pc1;
        inst_d[tail_p1] = c_inst1;
        excp_d[tail_p1] = c_excp1;
      end
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage, intentionally left unreset.
  always_ff @(posedge clk) begin
    pc_q   <= pc_d;
    inst_q <= inst_d;
    excp_q <= excp_d;
  end

endmodule

// File: tb/tb_fetch_pair_buffer.sv
// tb/tb_fetch_pair_buffer.sv - randomized self-checking bench for fetch_pair_buffer
`ifndef INST_NOP
`define INST_NOP 32'h03400000
`endif

module tb_fetch_pair_buffer;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  excp;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        if_readygo = 1'b0;
  logic        fb_allowin;
  logic [1:0]  if_fb_valid = 2'b00;
  logic [31:0] if_fb_pc0 = '0, if_fb_pc1 = '0, if_fb_inst0 = '0, if_fb_inst1 = '0;
  logic [6:0]  if_fb_excp0 = '0, if_fb_excp1 = '0;
  logic        fb_readygo;
  logic        id_allowin = 1'b0;
  logic [1:0]  fb_id_valid;
  logic [31:0] fb_id_pc0, fb_id_pc1, fb_id_inst0, fb_id_inst1;
  logic [6:0]  fb_id_excp0, fb_id_excp1;

  fetch_pair_buffer #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_readygo(if_readygo), .fb_allowin(fb_allowin),
    .if_fb_valid(if_fb_valid),
    .if_fb_pc0(if_fb_pc0), .if_fb_pc1(if_fb_pc1),
    .if_fb_inst0(if_fb_inst0), .if_fb_inst1(if_fb_inst1),
    .if_fb_excp0(if_fb_excp0), .if_fb_excp1(if_fb_excp1),
    .fb_readygo(fb_readygo), .id_allowin(id_allowin),
    .fb_id_valid(fb_id_valid),
    .fb_id_pc0(fb_id_pc0), .fb_id_pc1(fb_id_pc1),
    .fb_id_inst0(fb_id_inst0), .fb_id_inst1(fb_id_inst1),
    .fb_id_excp0(fb_id_excp0), .fb_id_excp1(fb_id_excp1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  ent_t q[$];
  logic [31:0] next_pc = 32'h1c000000;
  int pushed_n = 0;
  int dut_popped = 0;

  ent_t       exp_s0, exp_s1, idle_e;
  logic [1:0] exp_valid;
  logic       exp_allow, exp_rdy;

  initial idle_e = '{pc: 32'h0, inst: `INST_NOP, excp: 7'h0};

  task automatic drive(input logic rdy, input logic [1:0] v, input logic ida, input logic fl);
    if_readygo  = rdy;
    if_fb_valid = v;
    id_allowin  = ida;
    flush       = fl;
    if_fb_pc0   = (v == 2'b10) ? $urandom : next_pc;
    if_fb_pc1   = (v == 2'b11) ? next_pc + 32'd4 : ((v == 2'b10) ? next_pc : $urandom);
    if_fb_inst0 = $urandom;
    if_fb_inst1 = $urandom;
    if_fb_excp0 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd0;
    if_fb_excp1 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd0;
  endtask

  // Instructions offered this cycle, oldest first, with holes removed.
  task automatic get_compacted(output ent_t c0, output ent_t c1, output int n);
    ent_t lst[$];
    if (if_fb_valid[0]) lst.push_back('{pc: if_fb_pc0, inst: if_fb_inst0, excp: if_fb_excp0});
    if (if_fb_valid[1]) lst.push_back('{pc: if_fb_pc1, inst: if_fb_inst1, excp: if_fb_excp1});
    n  = lst.size();
    c0 = (n >= 1) ? lst[0] : idle_e;
    c1 = (n >= 2) ? lst[1] : idle_e;
  endtask

  task automatic model_update();
    ent_t c0, c1;
    int   n;
    bit   acc, take;
    get_compacted(c0, c1, n);
    if (rst || flush) begin
      q.delete();
    end else begin
      acc  = if_readygo && (q.size() <= DEPTH - 2);
      take = 1'b0;
`ifdef FB_BYPASS_EN
      if (acc && q.size() == 0 && n > 0 && id_allowin) take = 1'b1;
`endif
      if (id_allowin && q.size() > 0) begin
        repeat ((q.size() >= 2) ? 2 : 1) void'(q.pop_front());
      end
      if (acc && !take) begin
        if (n >= 1) q.push_back(c0);
        if (n == 2) q.push_back(c1);
      end
      if (acc) begin
        next_pc  += 32'(4 * n);
        pushed_n += n;
      end
    end
  endtask

  task automatic calc_expected();
    ent_t c0, c1;
    int   n;
    get_compacted(c0, c1, n);
    exp_valid = {q.size() >= 2, q.size() >= 1};
    exp_s0    = (q.size() >= 1) ? q[0] : idle_e;
    exp_s1    = (q.size() >= 2) ? q[1] : idle_e;
`ifdef FB_BYPASS_EN
    if (q.size() == 0 && if_readygo && n > 0) begin
      exp_valid = (n == 2) ? 2'b11 : 2'b01;
      exp_s0    = c0;
      exp_s1    = (n == 2) ? c1 : idle_e;
    end
`endif
    exp_allow = (q.size() <= DEPTH - 2);
    exp_rdy   = exp_valid[0];
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 2'b00, 0, 0);
    advance();
    advance();
    rst = 1'b0;
    drive(0, 2'b00, 0, 0);
    #1;
    checks += 4;
    if (fb_readygo !== 1'b0) begin errors++; $display("FAIL reset_readygo got=%b exp=0", fb_readygo); end
    if (fb_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got=%b exp=1", fb_allowin); end
    if (fb_id_valid !== 2'b00) begin errors++; $display("FAIL reset_valid got=%b exp=00", fb_id_valid); end
    if (fb_id_inst0 !== `INST_NOP) begin errors++; $display("FAIL reset_inst0 got=%h exp=%h", fb_id_inst0, `INST_NOP); end
    advance();
  endtask

  task automatic test_pair_push();
    next_pc = 32'h1c000000;
    drive(1, 2'b11, 1, 0);
    #1;
`ifdef FB_BYPASS_EN
    checks++;
    if (fb_id_valid !== 2'b11) begin errors++; $display("FAIL pair_bypass_valid got=%b exp=11", fb_id_valid); end
`endif
    advance();
    drive(0, 2'b00, 1, 0);
    #1;
`ifndef FB_BYPASS_EN
    checks += 3;
    if (fb_id_valid !== 2'b11) begin errors++; $display("FAIL pair_valid got=%b exp=11", fb_id_valid); end
    if (fb_id_pc0 !== 32'h1c000000) begin errors++; $display("FAIL pair_pc0 got=%h exp=1c000000", fb_id_pc0); end
    if (fb_id_pc1 !== 32'h1c000004) begin errors++; $display("FAIL pair_pc1 got=%h exp=1c000004", fb_id_pc1); end
`endif
    advance();
    drive(0, 2'b00, 1, 0);
    #1;
    checks++;
    if (fb_readygo !== 1'b0) begin errors++; $display("FAIL pair_drained got=%b exp=0", fb_readygo); end
    advance();
  endtask

  task automatic test_single_slot1();
    next_pc = 32'h1c000004;
    drive(1, 2'b10, 0, 0);
    if_fb_inst1 = 32'h02800c21;
    advance();
    drive(0, 2'b00, 0, 0);
    #1;
    checks += 3;
    if (fb_id_pc0 !== 32'h1c000004) begin errors++; $display("FAIL single_pc0 got=%h exp=1c000004", fb_id_pc0); end
    if (fb_id_inst0 !== 32'h02800c21) begin errors++; $display("FAIL single_inst0 got=%h exp=02800c21", fb_id_inst0); end
    if (fb_id_valid !== 2'b01) begin errors++; $display("FAIL single_valid got=%b exp=01", fb_id_valid); end
    drive(0, 2'b00, 1, 0);
    advance();
  endtask

  task automatic test_fill_drain();
    logic [31:0] base;
    drive(0, 2'b00, 0, 1);
    advance();
    base = next_pc;
    for (int i = 0; i < 3; i++) begin drive(1, 2'b11, 0, 0); advance(); end
    drive(1, 2'b01, 0, 0);
    advance();
    drive(1, 2'b11, 0, 0);
    #1;
    checks++;
    if (fb_allowin !== 1'b0) begin errors++; $display("FAIL fill_allow7 got=%b exp=0", fb_allowin); end
    advance();
    for (int k = 0; k < 4; k++) begin
      drive(0, 2'b00, 1, 0);
      #1;
      checks += 2;
      if (fb_id_valid !== ((k < 3) ? 2'b11 : 2'b01)) begin errors++; $display("FAIL drain_valid k=%0d got=%b", k, fb_id_valid); end
      if (fb_id_pc0 !== base + 32'(8 * k)) begin errors++; $display("FAIL drain_pc0 k=%0d got=%h exp=%h", k, fb_id_pc0, base + 32'(8 * k)); end
      advance();
    end
    drive(0, 2'b00, 0, 0);
    #1;
    checks++;
    if (fb_readygo !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", fb_readygo); end
    for (int i = 0; i < 3; i++) begin drive(1, 2'b11, 0, 0); advance(); end
    drive(1, 2'b11, 0, 0);
    #1;
    checks++;
    if (fb_allowin !== 1'b1) begin errors++; $display("FAIL fill_allow6 got=%b exp=1", fb_allowin); end
    advance();
    drive(0, 2'b00, 0, 0);
    #1;
    checks += 2;
    if (fb_allowin !== 1'b0) begin errors++; $display("FAIL fill_allow8 got=%b exp=0", fb_allowin); end
    if (fb_id_valid !== 2'b11) begin errors++; $display("FAIL fill_valid8 got=%b exp=11", fb_id_valid); end
    drive(0, 2'b00, 0, 1);
    advance();
  endtask

  task automatic test_wrap();
    logic [31:0] wpc;
    int packets, cyc;
    drive(0, 2'b00, 0, 1);
    advance();
    for (int i = 0; i < 3; i++) begin drive(1, 2'b11, 0, 0); advance(); end
    for (int i = 0; i < 3; i++) begin drive(0, 2'b00, 1, 0); advance(); end
    drive(1, 2'b01, 0, 0); advance();
    drive(0, 2'b00, 1, 0); advance();
    wpc = next_pc;
    drive(1, 2'b11, 0, 0); advance();
    drive(1, 2'b01, 0, 0); advance();
    drive(0, 2'b00, 0, 0);
    #1;
    checks += 3;
    if (fb_id_valid !== 2'b11) begin errors++; $display("FAIL wrap_valid got=%b exp=11", fb_id_valid); end
    if (fb_id_pc0 !== wpc) begin errors++; $display("FAIL wrap_pc0 got=%h exp=%h", fb_id_pc0, wpc); end
    if (fb_id_pc1 !== wpc + 32'd4) begin errors++; $display("FAIL wrap_pc1 got=%h exp=%h", fb_id_pc1, wpc + 32'd4); end
    drive(0, 2'b00, 1, 0);
    advance();
    drive(0, 2'b00, 0, 0);
    #1;
    checks += 2;
    if (fb_id_valid !== 2'b01) begin errors++; $display("FAIL wrap_tail_valid got=%b exp=01", fb_id_valid); end
    if (fb_id_pc0 !== wpc + 32'd8) begin errors++; $display("FAIL wrap_tail_pc0 got=%h exp=%h", fb_id_pc0, wpc + 32'd8); end

    pushed_n   = q.size();
    dut_popped = 0;
    packets    = 0;
    cyc        = 0;
    while ((packets < 20 || q.size() != 0) && cyc < 600) begin
      if (packets < 20)
        drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0, 0);
      else
        drive(0, 2'b00, 1, 0);
      #1;
      calc_expected();
      checks += 5;
      if (fb_id_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, fb_id_valid, exp_valid); end
      if ({fb_id_pc0, fb_id_inst0, fb_id_excp0} !== exp_s0) begin errors++; $display("FAIL rnd_slot0 cyc=%0d got=%h exp=%h", cyc, {fb_id_pc0, fb_id_inst0, fb_id_excp0}, exp_s0); end
      if ({fb_id_pc1, fb_id_inst1, fb_id_excp1} !== exp_s1) begin errors++; $display("FAIL rnd_slot1 cyc=%0d got=%h exp=%h", cyc, {fb_id_pc1, fb_id_inst1, fb_id_excp1}, exp_s1); end
      if (fb_allowin !== exp_allow) begin errors++; $display("FAIL rnd_allowin cyc=%0d got=%b exp=%b", cyc, fb_allowin, exp_allow); end
      if (fb_readygo !== exp_rdy) begin errors++; $display("FAIL rnd_readygo cyc=%0d got=%b exp=%b", cyc, fb_readygo, exp_rdy); end
      if (fb_readygo && id_allowin) dut_popped += int'(fb_id_valid[0]) + int'(fb_id_valid[1]);
      if (if_readygo && exp_allow && if_fb_valid != 2'b00) packets++;
      advance();
      cyc++;
    end
    checks += 2;
    if (cyc >= 600) begin errors++; $display("FAIL rnd_timeout got=%0d packets exp=20 drained", packets); end
    if (dut_popped != pushed_n) begin errors++; $display("FAIL rnd_conservation got=%0d popped exp=%0d", dut_popped, pushed_n); end
  endtask

  task automatic test_flush();
    drive(0, 2'b00, 0, 1);
    advance();
    drive(1, 2'b11, 0, 0); advance();
    drive(1, 2'b11, 0, 0); advance();
    drive(1, 2'b11, 0, 1);
    advance();
    drive(0, 2'b00, 0, 0);
    #1;
    checks += 4;
    if (fb_readygo !== 1'b0) begin errors++; $display("FAIL flush_readygo got=%b exp=0", fb_readygo); end
    if (fb_id_valid !== 2'b00) begin errors++; $display("FAIL flush_valid got=%b exp=00", fb_id_valid); end
    if (fb_id_pc0 !== 32'h0) begin errors++; $display("FAIL flush_pc0 got=%h exp=0", fb_id_pc0); end
    if (fb_allowin !== 1'b1) begin errors++; $display("FAIL flush_allowin got=%b exp=1", fb_allowin); end
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pair_push();
    test_single_slot1();
    test_fill_drain();
    test_wrap();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
